// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter using double dabble, one bit per clock.
// Optional macro BIN_TO_BCD_SAT_EN clamps overflowing results to 99_999_999.
module bin_to_bcd #(
    parameter int BIN_W = 27
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bcd,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [31:0] BCD_MAX = 32'd99_999_999;

    logic [1:0]       state;
    logic [BIN_W-1:0] shift_reg;
    logic [31:0]      acc;
    logic [31:0]      acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;
    logic [31:0]      bin_ext;

    assign bin_ext = 32'(bin);

    // Nibbles >= 5 get +3 so the following shift carries correctly into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= 32'h0;
            ovf       <= 1'b0;
            cnt       <= '0;
            shift_reg <= '0;
            acc       <= 32'h0;
            ovf_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        acc       <= 32'h0;
                        cnt       <= CNT_W'(BIN_W);
                        ovf_pend  <= (bin_ext > BCD_MAX);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The top accumulator bit falls off here, giving a result modulo 10^8.
                    acc       <= {acc_adj[30:0], shift_reg[BIN_W-1]};
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    cnt       <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef BIN_TO_BCD_SAT_EN
                    bcd <= ovf_pend ? 32'h9999_9999 : acc;
`else
                    bcd <= acc;
`endif
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd at the default width of 27.
// Honours BIN_TO_BCD_SAT_EN for the overflow expectations.
module tb_bin_to_bcd;

    logic        clk_50mhz;
    logic        rst_n;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_bcd #(.BIN_W(27)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

`ifdef BIN_TO_BCD_SAT_EN
    localparam logic [31:0] EXP_MAXIN = 32'h9999_9999;
    localparam logic [31:0] EXP_1E8   = 32'h9999_9999;
`else
    localparam logic [31:0] EXP_MAXIN = 32'h3421_7727;
    localparam logic [31:0] EXP_1E8   = 32'h0000_0000;
`endif

    // Callers sit on a falling edge; returns on the falling edge after the accepting edge.
    task automatic start_conv(input logic [26:0] v);
        bin   = v;
        start = 1'b1;
        @(negedge clk_50mhz);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_50mhz);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_50mhz);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk_50mhz);
        n_cmp++;
        if ({busy, done, ovf} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got busy/done/ovf=%b, expected 000", {busy, done, ovf});
        end
        n_cmp++;
        if (bcd !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_bcd: got %h, expected 00000000", bcd);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_basic;
        bit held_ok;
        start_conv(27'd12_345_678);
        held_ok = 1'b1;
        if (busy !== 1'b1) held_ok = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk_50mhz);
            if (busy !== 1'b1 || done !== 1'b0 || bcd !== 32'h0) held_ok = 1'b0;
        end
        n_cmp++;
        if (!held_ok) begin
            n_err++;
            $display("[TB] FAIL basic_busy_window: got early change, expected busy=1 done=0 bcd held for 28 cycles");
        end
        @(negedge clk_50mhz);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_done_edge: got done=%b busy=%b, expected done=1 busy=0", done, busy);
        end
        n_cmp++;
        if (bcd !== 32'h1234_5678 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_result: got bcd=%h ovf=%b, expected 12345678 ovf=0", bcd, ovf);
        end
        @(negedge clk_50mhz);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_done_width: got done=%b, expected 0", done);
        end
        repeat (5) @(negedge clk_50mhz);
        n_cmp++;
        if (bcd !== 32'h1234_5678) begin
            n_err++;
            $display("[TB] FAIL basic_hold: got %h, expected 12345678", bcd);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_conv(27'd0);
        wait_done(lat);
        n_cmp++;
        if (lat != 28 || bcd !== 32'h0 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_zero: got lat=%0d bcd=%h ovf=%b, expected lat=28 bcd=00000000 ovf=0", lat, bcd, ovf);
        end
        start_conv(27'd99_999_999);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_accept: got busy=%b, expected 1", busy);
        end
        wait_done(lat);
        n_cmp++;
        if (lat != 28 || bcd !== 32'h9999_9999 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_max: got lat=%0d bcd=%h ovf=%b, expected lat=28 bcd=99999999 ovf=0", lat, bcd, ovf);
        end
    endtask

    task automatic test_overflow;
        int lat;
        @(negedge clk_50mhz);
        start_conv(27'd134_217_727);
        wait_done(lat);
        n_cmp++;
        if (lat != 28 || bcd !== EXP_MAXIN || ovf !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ovf_maxin: got lat=%0d bcd=%h ovf=%b, expected lat=28 bcd=%h ovf=1", lat, bcd, ovf, EXP_MAXIN);
        end
        start_conv(27'd100_000_000);
        wait_done(lat);
        n_cmp++;
        if (bcd !== EXP_1E8 || ovf !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ovf_1e8: got bcd=%h ovf=%b, expected bcd=%h ovf=1", bcd, ovf, EXP_1E8);
        end
        start_conv(27'd42);
        wait_done(lat);
        n_cmp++;
        if (bcd !== 32'h0000_0042 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ovf_clear: got bcd=%h ovf=%b, expected 00000042 ovf=0", bcd, ovf);
        end
    endtask

    task automatic test_values;
        int lat;
        start_conv(27'd5);
        wait_done(lat);
        n_cmp++;
        if (bcd !== 32'h0000_0005) begin
            n_err++;
            $display("[TB] FAIL val_5: got %h, expected 00000005", bcd);
        end
        start_conv(27'd10_000_000);
        wait_done(lat);
        n_cmp++;
        if (bcd !== 32'h1000_0000) begin
            n_err++;
            $display("[TB] FAIL val_1e7: got %h, expected 10000000", bcd);
        end
        start_conv(27'd90_807_060);
        wait_done(lat);
        n_cmp++;
        if (bcd !== 32'h9080_7060) begin
            n_err++;
            $display("[TB] FAIL val_mixed: got %h, expected 90807060", bcd);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        int extra;
        bit early;
        start_conv(27'd87_654_321);
        early = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            if (k == 9) begin
                bin   = 27'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_50mhz);
            if (done === 1'b1) early = 1'b1;
        end
        start = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (early || lat != 1 || bcd !== 32'h8765_4321) begin
            n_err++;
            $display("[TB] FAIL ignore_result: got early=%b lat=%0d bcd=%h, expected early=0 lat=1 bcd=87654321", early, lat, bcd);
        end
        count_dones(40, extra);
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("[TB] FAIL ignore_extra_done: got %0d, expected 0", extra);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int n;
        start_conv(27'd89_012_345);
        repeat (14) @(negedge clk_50mhz);
        rst_n = 1'b0;
        @(negedge clk_50mhz);
        n_cmp++;
        if (bcd !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_state: got bcd=%h busy=%b done=%b ovf=%b, expected 0 0 0 0", bcd, busy, done, ovf);
        end
        rst_n = 1'b1;
        count_dones(40, n);
        n_cmp++;
        if (n != 0 || bcd !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL abort_no_done: got dones=%0d bcd=%h, expected 0 00000000", n, bcd);
        end
        start_conv(27'd12_345_678);
        wait_done(lat);
        n_cmp++;
        if (lat != 28 || bcd !== 32'h1234_5678) begin
            n_err++;
            $display("[TB] FAIL abort_recover: got lat=%0d bcd=%h, expected lat=28 bcd=12345678", lat, bcd);
        end
    endtask

    task automatic test_reset_with_start;
        int n;
        rst_n = 1'b0;
        bin   = 27'd5;
        start = 1'b1;
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rst_start_busy: got %b, expected 0", busy);
        end
        count_dones(35, n);
        n_cmp++;
        if (n != 0 || bcd !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL rst_start_done: got dones=%0d bcd=%h, expected 0 00000000", n, bcd);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_overflow;
        test_values;
        test_start_ignored;
        test_reset_abort;
        test_reset_with_start;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 27, giving the binary input width; legal range is 4..27.
REQ-002 SHALL have port clk_50mhz  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to convert bin; acted on only when busy=0.
REQ-005 SHALL have port bin  input  BIN_W  unsigned binary value, sampled on the accepting edge.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking the cycle that bcd is updated.
REQ-008 SHALL have port bcd  output  32  packed 8-digit BCD with digit 7 in [31:28]; drives dis_data of the 7-segment driver directly.
REQ-009 SHALL have port ovf  output  1  high when the last accepted bin exceeded 99_999_999.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 In IDLE, start=1 at edge N SHALL latch bin into a shift register, clear the BCD accumulator, load the iteration counter with BIN_W, and enter SHIFT with busy=1 from edge N.
REQ-012 In SHIFT, each cycle SHALL first add 3 to every accumulator nibble that is >=5, then shift {accumulator, shift register} left by 1, then decrement the counter.
REQ-013 After exactly BIN_W SHIFT cycles (edges N+1..N+BIN_W), the FSM SHALL enter DONE.
REQ-014 At edge N+BIN_W+1 the block SHALL register bcd and ovf, drive done=1 and busy=0, and return to IDLE; latency from start to done is BIN_W+1 cycles, which is 28 at the default width.
REQ-015 done SHALL be high for exactly one cycle per accepted start.
REQ-016 bcd and ovf SHALL hold their values between conversions and change only on a done edge or on reset.
REQ-017 start while busy=1 SHALL be ignored and SHALL NOT alter the conversion in flight.
REQ-018 start SHALL be accepted in the cycle done=1 (busy=0), giving back-to-back conversions with no idle gap.
REQ-019 ovf SHALL be 1 when the latched bin > 99_999_999 and 0 otherwise; for BIN_W <= 26, ovf is always 0 except at BIN_W=27.
REQ-020 Bits carried out of the 32-bit accumulator SHALL be discarded, so an unsaturated result equals bin mod 10^8.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force state=IDLE, busy=0, done=0, bcd=32'h0, ovf=0, counter=0 and shift register=0.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion and leave bcd=0 with no done pulse.
REQ-023 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-024 Macro BIN_TO_BCD_SAT_EN SHALL control saturation of overflowing inputs.
REQ-025 With BIN_TO_BCD_SAT_EN defined, a conversion with ovf=1 SHALL output bcd=32'h99999999 on its done edge.
REQ-026 Without BIN_TO_BCD_SAT_EN, a conversion with ovf=1 SHALL output bin mod 10^8 in BCD; ovf is still reported.
REQ-027 Latency and handshake SHALL be identical with and without the macro.

Verification
REQ-028 Reset, then start with bin=12_345_678 -> busy=1 for 28 cycles, then done=1 for one cycle with bcd=32'h12345678 and ovf=0.
REQ-029 bin=0, then bin=99_999_999 issued back-to-back on the done cycle -> bcd=32'h00000000, then 28 cycles later bcd=32'h99999999; ovf=0 both times.
REQ-030 bin=134_217_727 -> ovf=1; bcd=32'h99999999 with the macro, 32'h34217727 without it.
REQ-031 Start bin=87_654_321, pulse start with bin=1 at cycle 10 -> single done at cycle 28 with bcd=32'h87654321.
REQ-032 Start bin=89_012_345, drive rst_n=0 at cycle 15 -> bcd=0, busy=0, no done; a new start after release converts normally.
REQ-033 Connect bcd to the display driver's dis_data with en=1 -> sel/seg scan the digits 1,2,3,4,5,6,7,8 for bin=12_345_678.
